wfifo_ingress: RTL and testbench

//   Write-side ingress stage of the async FIFO, in the write clock domain, directly upstream of wptr_full.

---
 rtl/wfifo_ingress.sv | 189 ++++++++++++++++++
 tb/tb_wfifo_ingress.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfifo_ingress.sv
// -----------------------------------------------------------------------------
// wfifo_ingress
//
// Write-side ingress stage of the async FIFO, in the write clock domain,
// sitting directly upstream of wptr_full. It converts a valid/ready producer
// stream into the FIFO write port (winc/wdata).
//
// The full flag from wptr_full is registered, and in_ready is registered here
// as well. That gives the producer one cycle of backpressure latency. A
// 2-entry skid buffer (head h, tail t) absorbs the word that can still arrive
// during that cycle, so no word is lost or duplicated.
//
// Ports
//   wclk        in   1           write-domain clock
//   rst_n       in   1           asynchronous, active-low reset
//   in_valid    in   1           producer word valid
//   in_data     in   DATA_WIDTH  producer word
//   in_ready    out  1           registered; a word is accepted on the edge
//                                where in_valid & in_ready
//   full        in   1           registered full flag from wptr_full
//   winc        out  1           FIFO write strobe; word written on the edge
//                                where it is high
//   wdata       out  DATA_WIDTH  FIFO write data, valid whenever winc = 1
//
// Optional build macro: WFIFO_INGRESS_STATS_EN
//   When defined, two saturating 16-bit statistics counters are added:
//   wr_count     out 16  number of words written (edges with winc = 1)
//   stall_count  out 16  number of cycles with a buffered word but full = 1
//   The datapath is the same whether or not the macro is defined.
// -----------------------------------------------------------------------------
module wfifo_ingress #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  full,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata
`ifdef WFIFO_INGRESS_STATS_EN
    ,
    output logic [15:0]           wr_count,
    output logic [15:0]           stall_count
`endif
);

    // Occupancy of the skid buffer. EMPTY holds no word, ONE holds h, and
    // TWO holds h followed by t.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e                state_q,    state_d;
    logic [DATA_WIDTH-1:0] h_q,        h_d;
    logic [DATA_WIDTH-1:0] t_q,        t_d;
    logic                  in_ready_q, in_ready_d;

    logic push;
    logic pop;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // winc is built from registered state and the registered full flag only.
    // It therefore never combines with in_valid, and it can never be high
    // while full is high, whatever gating wptr_full applies downstream.
    assign winc     = (state_q != ST_EMPTY) && !full;
    assign wdata    = h_q;
    assign in_ready = in_ready_q;

    assign push = in_valid && in_ready_q;
    assign pop  = winc;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default at the top of the block.
    // Any path that skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        t_d     = t_q;

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    h_d     = in_data;
                end
            end

            ST_ONE: begin
                if (push && pop) begin
                    // h leaves on this edge and is replaced by the new word.
                    h_d = in_data;
                end else if (push) begin
                    // The word that arrives during the backpressure cycle
                    // lands in the skid entry.
                    state_d = ST_TWO;
                    t_d     = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end

            ST_TWO: begin
                // in_ready_q is low throughout TWO, so push cannot occur here.
                if (pop) begin
                    state_d = ST_ONE;
                    h_d     = t_q;
                end
            end

            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // in_ready is taken from the next state. The producer therefore sees
        // backpressure in the same cycle that the buffer becomes full, and
        // the skid entry is always free while in_ready is high.
        in_ready_d = (state_d != ST_TWO);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge value, whatever the order of the
    // statements below.
    //
    // NOTE: the data registers h/t are reset as well as the control state.
    // This keeps wdata at a defined 0 out of reset and clears any word that
    // was buffered when reset was asserted.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            h_q        <= '0;
            t_q        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            t_q        <= t_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef WFIFO_INGRESS_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics counters (saturating; they hold at all-ones and never wrap)
    // -------------------------------------------------------------------------
    logic [15:0] wr_count_q,    wr_count_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        stall;

    // A stall is a cycle with a word ready to go that wptr_full refuses.
    assign stall = (state_q != ST_EMPTY) && full;

    always_comb begin
        wr_count_d    = wr_count_q;
        stall_count_d = stall_count_q;
        if (pop && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            wr_count_q    <= wr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_wfifo_ingress.sv
// -----------------------------------------------------------------------------
// tb_wfifo_ingress
//
// Self-checking bench for wfifo_ingress. It applies directed vectors with
// hand-computed expectations. A scoreboard queue checks ordering during the
// randomised full/in_valid phase.
//
// Inputs change 1 ns after each rising wclk edge. Outputs are sampled 1 ns
// after that, which is well away from the active edge.
// When WFIFO_INGRESS_STATS_EN is defined, the statistics counters are also
// checked.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wfifo_ingress;

    localparam int DW = 8;

    logic          wclk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          full;
    logic          winc;
    logic [DW-1:0] wdata;
`ifdef WFIFO_INGRESS_STATS_EN
    logic [15:0]   wr_count;
    logic [15:0]   stall_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    wfifo_ingress #(.DATA_WIDTH(DW)) dut (
        .wclk       (wclk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .full       (full),
        .winc       (winc),
        .wdata      (wdata)
`ifdef WFIFO_INGRESS_STATS_EN
        ,
        .wr_count   (wr_count),
        .stall_count(stall_count)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Global time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the next rising edge, then move 1 ns past it.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // Apply inputs, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic f);
        in_valid = v;
        in_data  = d;
        full     = f;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        tick();
        tick();
        @(negedge wclk);
        rst_n = 1'b1;
        tick();
    endtask

    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_w;
    int            sent;
    int            rcv;
    int            cyc;
    int            winc_full_err;
    logic          v_r;
    logic          f_r;
    logic [DW-1:0] d_r;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        full     = 1'b0;

        // ---------------- Reset state and release ----------------
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_winc",     winc,     1'b0);
        check("rst_wdata",    wdata,    8'h00);
        @(negedge wclk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", in_ready, 1'b0);
        tick();
        check("rel_in_ready_after_edge", in_ready, 1'b1);
        check("rel_winc_idle", winc, 1'b0);
        tick();
        check("idle_winc", winc, 1'b0);

        // ---------------- Back-to-back stream 0x01..0x10 ----------------
        drive(1'b1, 8'h01, 1'b0);
        check("stream_winc_before_first", winc, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0);
            tick();
            check($sformatf("stream_winc_%0d", i), winc, 1'b1);
            check($sformatf("stream_wdata_%0d", i), wdata, 32'(i + 1));
            check($sformatf("stream_ready_%0d", i), in_ready, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check("stream_drained_winc", winc, 1'b0);

        // ---------------- full held high, then released ----------------
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        check("full_one_winc",  winc,     1'b0);
        check("full_one_ready", in_ready, 1'b1);
        check("full_one_wdata", wdata,    8'hA5);
        drive(1'b1, 8'h5A, 1'b1);
        tick();
        check("full_two_ready", in_ready, 1'b0);
        check("full_two_winc",  winc,     1'b0);
        check("full_two_wdata", wdata,    8'hA5);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("full_hold_ready", in_ready, 1'b0);
        check("full_hold_wdata", wdata,    8'hA5);
        drive(1'b0, 8'h00, 1'b0);
        check("full_drop_winc_same_cycle", winc,  1'b1);
        check("full_drop_wdata0",          wdata, 8'hA5);
        tick();
        check("full_drop_winc1",  winc,     1'b1);
        check("full_drop_wdata1", wdata,    8'h5A);
        check("full_drop_ready",  in_ready, 1'b1);
        tick();
        check("full_drop_empty", winc, 1'b0);

        // ---------------- Random full / in_valid, 1000 words ----------------
        sent          = 0;
        rcv           = 0;
        cyc           = 0;
        winc_full_err = 0;
        while (rcv < 1000 && cyc < 20000) begin
            v_r = (sent < 1000) && ($urandom_range(0, 9) < 7);
            f_r = ($urandom_range(0, 1) == 1);
            d_r = 8'($urandom_range(0, 255));
            drive(v_r, d_r, f_r);
            if (winc && full) winc_full_err++;
            if (winc) begin
                if (sb_q.size() == 0) begin
                    check("sb_pop_with_empty_model", 32'(rcv), 32'hFFFF_FFFF);
                end else begin
                    exp_w = sb_q.pop_front();
                    check($sformatf("sb_word_%0d", rcv), wdata, exp_w);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
                sent++;
            end
            tick();
            cyc++;
        end
        drive(1'b0, 8'h00, 1'b0);
        check("rand_sent",          sent,          1000);
        check("rand_received",      rcv,           1000);
        check("rand_sb_empty",      sb_q.size(),   0);
        check("rand_never_winc_full", winc_full_err, 0);
        tick();
        tick();
        check("rand_no_extra_winc", winc, 1'b0);

        // ---------------- Reset while holding two words ----------------
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        drive(1'b1, 8'h5A, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        check("mid_rst_two_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_winc",     winc,     1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_wdata",    wdata,    8'h00);
        drive(1'b0, 8'h00, 1'b0);
        check("mid_rst_winc_full_low", winc, 1'b0);
        tick();
        @(negedge wclk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready_before_edge", in_ready, 1'b0);
        tick();
        check("mid_rel_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_rel_no_stale_%0d", i), winc, 1'b0);
            tick();
        end
        check("mid_rel_wdata", wdata, 8'h00);

`ifdef WFIFO_INGRESS_STATS_EN
        // ---------------- Statistics counters ----------------
        do_reset();
        check("stats_rst_wr",    wr_count,    16'h0000);
        check("stats_rst_stall", stall_count, 16'h0000);
        // Push with full=1 from EMPTY: this edge is not a stall.
        drive(1'b1, 8'h11, 1'b1);
        tick();
        // Seven edges holding one word while full=1.
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        // Release full: word 1 pops, then 19 more stream through.
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("stats_wr_20",    wr_count,    16'd20);
        check("stats_stall_7",  stall_count, 16'd7);
        for (int k = 0; k < 70000; k++) begin
            drive(1'b1, 8'(k), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("stats_wr_sat",       wr_count,    16'hFFFF);
        check("stats_stall_steady", stall_count, 16'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
